// File: rtl/aes_ks_pkg.sv
// Shared types, constants and byte-level helpers for the AES-256 key schedule.
package aes_ks_pkg;

    localparam int unsigned NUM_RK    = 15;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned LAST_STEP = 12;
    localparam int unsigned KEY_W     = 256;
    localparam int unsigned RK_W      = 128;

    typedef logic [RK_W-1:0] rk_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Round constant for an even step; argument is the step number divided by two.
    function automatic logic [7:0] rcon(input logic [2:0] half_step);
        return 8'(8'h01 << half_step);
    endfunction

endpackage

// File: rtl/aes_ks_step.sv
// One combinational AES-256 expansion step over the 8-word window.
module aes_ks_step
    import aes_ks_pkg::*;
(
    input  logic [255:0] state_i,
    input  logic         is_even_i,
    input  logic [7:0]   rcon_i,
    output logic [255:0] next_o,
    output rk_t          rk_o
);

    logic [31:0] w7;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    // Even steps rotate the newest word and add rcon; odd steps only substitute it.
    assign w7      = state_i[31:0];
    assign sub_in  = is_even_i ? {w7[23:0], w7[31:24]} : w7;
    assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                      sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    assign temp    = sub_out ^ (is_even_i ? {rcon_i, 24'h000000} : 32'h0);

    assign n0 = state_i[255:224] ^ temp;
    assign n1 = state_i[223:192] ^ n0;
    assign n2 = state_i[191:160] ^ n1;
    assign n3 = state_i[159:128] ^ n2;

    assign next_o = {state_i[127:0], n0, n1, n2, n3};
    assign rk_o   = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-256 key-schedule controller with a zeroizable round-key store.
module aes_key_sched_ctrl
    import aes_ks_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic [255:0]   key_in,
    input  logic           clear,
    output logic           busy,
    output logic           done,
    output logic           keys_valid,
    output logic [3:0]     rk_avail,
    input  logic [3:0]     rk_rd_idx,
    output logic [127:0]   rk_rd_data
);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   work_q, work_d;
    logic [IDX_W-1:0]   step_q, step_d;
    logic [IDX_W-1:0]   avail_q, avail_d;
    logic               kv_q, kv_d;
    logic               done_q, done_d;
    logic               busy_q;
    rk_t                rd_data_q, rd_data_d;
    rk_t                rk_q [NUM_RK];

    logic               accept;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    rk_t                wr_data;
    logic [7:0]         rcon_val;
    logic [KEY_W-1:0]   step_next;
    rk_t                step_out;

    assign key_ready = (state_q != EXPAND) && !clear;
    assign accept    = key_valid && key_ready;
    assign rcon_val  = rcon(step_q[3:1]);

    aes_ks_step u_step (
        .state_i   (work_q),
        .is_even_i (~step_q[0]),
        .rcon_i    (rcon_val),
        .next_o    (step_next),
        .rk_o      (step_out)
    );

    // Next-state, expansion datapath and masked read-port selection.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        step_d    = step_q;
        avail_d   = avail_q;
        kv_d      = kv_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        rd_data_d = '0;

        if (accept) begin
            state_d = EXPAND;
            work_d  = key_in;
            step_d  = '0;
            avail_d = IDX_W'(2);
            kv_d    = 1'b0;
        end else if (state_q == EXPAND) begin
            work_d  = step_next;
            wr_en   = 1'b1;
            wr_idx  = step_q + IDX_W'(2);
            wr_data = step_out;
            avail_d = step_q + IDX_W'(3);
            step_d  = step_q + IDX_W'(1);
            if (step_q == IDX_W'(LAST_STEP)) begin
                state_d = READY;
                kv_d    = 1'b1;
                done_d  = 1'b1;
            end
        end

        if (rk_rd_idx < avail_q) begin
            rd_data_d = rk_q[rk_rd_idx];
        end
    end

    // Control and read-port registers; rst and clear both flush everything.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q   <= IDLE;
            work_q    <= '0;
            step_q    <= '0;
            avail_q   <= '0;
            kv_q      <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            step_q    <= step_d;
            avail_q   <= avail_d;
            kv_q      <= kv_d;
            done_q    <= done_d;
            busy_q    <= (state_d == EXPAND);
            rd_data_q <= rd_data_d;
        end
    end

    // Round-key store: key halves on accept, one expanded key per step.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int unsigned i = 0; i < NUM_RK; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                rk_q[0] <= key_in[255:128];
                rk_q[1] <= key_in[127:0];
            end
            if (wr_en) begin
                rk_q[wr_idx] <= wr_data;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;
    assign rk_avail   = avail_q;
    assign rk_rd_data = rd_data_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed self-checking bench for the AES-256 key-schedule controller.
module tb_aes_key_sched_ctrl;

    localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] A3_KEY  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] C3_RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] C3_RK5  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
    localparam logic [127:0] C3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key_in;
    logic         clear;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_avail;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .clear      (clear),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_avail   (rk_avail),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_key(input logic [255:0] k);
        key_valid = 1'b1;
        key_in    = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = ~k;
    endtask

    task automatic read_idx(input logic [3:0] idx, output logic [127:0] d);
        rk_rd_idx = idx;
        @(negedge clk);
        d = rk_rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; key_valid = 1'b0; key_in = '0; rk_rd_idx = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reset_kv: got %b want 0", keys_valid); end
        n_checks++; if (rk_avail !== 4'd0) begin n_fail++; $display("FAIL reset_avail: got %0d want 0", rk_avail); end
        n_checks++; if (rk_rd_data !== 128'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", rk_rd_data); end
        rst = 1'b0;
        #1;
        n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", key_ready); end
    endtask

    // C.3 expansion with early read of index 5 and key_valid held during EXPAND.
    task automatic test_c3_expand();
        logic [3:0]   exp_avail;
        logic [127:0] exp_rd;
        logic [127:0] d;
        rk_rd_idx = 4'd5;
        start_key(C3_KEY);
        for (int n = 0; n <= 14; n++) begin
            exp_avail = (n >= 13) ? 4'd15 : 4'(n + 2);
            exp_rd    = (n >= 5) ? C3_RK5 : 128'h0;
            n_checks++; if (rk_avail !== exp_avail) begin n_fail++; $display("FAIL c3_avail n=%0d: got %0d want %0d", n, rk_avail, exp_avail); end
            n_checks++; if (busy !== (n <= 12)) begin n_fail++; $display("FAIL c3_busy n=%0d: got %b want %b", n, busy, (n <= 12)); end
            n_checks++; if (done !== (n == 13)) begin n_fail++; $display("FAIL c3_done n=%0d: got %b want %b", n, done, (n == 13)); end
            n_checks++; if (keys_valid !== (n >= 13)) begin n_fail++; $display("FAIL c3_kv n=%0d: got %b want %b", n, keys_valid, (n >= 13)); end
            n_checks++; if (rk_rd_data !== exp_rd) begin n_fail++; $display("FAIL c3_early_rd5 n=%0d: got %h want %h", n, rk_rd_data, exp_rd); end
            n_checks++; if (key_ready !== (n >= 13)) begin n_fail++; $display("FAIL c3_ready n=%0d: got %b want %b", n, key_ready, (n >= 13)); end
            key_valid = (n < 12);
            key_in    = A3_KEY;
            @(negedge clk);
        end
        key_valid = 1'b0;
        read_idx(4'd0, d);
        n_checks++; if (d !== C3_KEY[255:128]) begin n_fail++; $display("FAIL c3_rk0: got %h want %h", d, C3_KEY[255:128]); end
        read_idx(4'd1, d);
        n_checks++; if (d !== C3_KEY[127:0]) begin n_fail++; $display("FAIL c3_rk1: got %h want %h", d, C3_KEY[127:0]); end
        read_idx(4'd2, d);
        n_checks++; if (d !== C3_RK2) begin n_fail++; $display("FAIL c3_rk2: got %h want %h", d, C3_RK2); end
        read_idx(4'd14, d);
        n_checks++; if (d !== C3_RK14) begin n_fail++; $display("FAIL c3_rk14: got %h want %h", d, C3_RK14); end
        read_idx(4'd15, d);
        n_checks++; if (d !== 128'h0) begin n_fail++; $display("FAIL c3_rk15: got %h want 0", d); end
    endtask

    // Rekey in READY with the A.3 key; index 14 is masked until rewritten.
    task automatic test_rekey_a3();
        logic [127:0] exp_rd;
        logic [127:0] d;
        rk_rd_idx = 4'd14;
        start_key(A3_KEY);
        n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL rekey_kv_drop: got %b want 0", keys_valid); end
        n_checks++; if (rk_avail !== 4'd2) begin n_fail++; $display("FAIL rekey_avail: got %0d want 2", rk_avail); end
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            exp_rd = (n == 14) ? A3_RK14 : 128'h0;
            n_checks++; if (rk_rd_data !== exp_rd) begin n_fail++; $display("FAIL rekey_rd14 n=%0d: got %h want %h", n, rk_rd_data, exp_rd); end
            n_checks++; if (done !== (n == 13)) begin n_fail++; $display("FAIL rekey_done n=%0d: got %b want %b", n, done, (n == 13)); end
        end
        read_idx(4'd0, d);
        n_checks++; if (d !== A3_KEY[255:128]) begin n_fail++; $display("FAIL a3_rk0: got %h want %h", d, A3_KEY[255:128]); end
        read_idx(4'd1, d);
        n_checks++; if (d !== A3_KEY[127:0]) begin n_fail++; $display("FAIL a3_rk1: got %h want %h", d, A3_KEY[127:0]); end
        read_idx(4'd14, d);
        n_checks++; if (d !== A3_RK14) begin n_fail++; $display("FAIL a3_rk14: got %h want %h", d, A3_RK14); end
    endtask

    // clear at step 6 together with key_valid flushes and zeroizes.
    task automatic test_clear_mid();
        logic [127:0] d;
        rk_rd_idx = 4'd0;
        start_key(C3_KEY);
        repeat (6) @(negedge clk);
        clear = 1'b1; key_valid = 1'b1; key_in = A3_KEY;
        #1;
        n_checks++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b want 0", key_ready); end
        @(negedge clk);
        clear = 1'b0; key_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %b want 0", busy); end
        n_checks++; if (rk_avail !== 4'd0) begin n_fail++; $display("FAIL clear_avail: got %0d want 0", rk_avail); end
        n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL clear_kv: got %b want 0", keys_valid); end
        n_checks++; if (rk_rd_data !== 128'h0) begin n_fail++; $display("FAIL clear_rd: got %h want 0", rk_rd_data); end
        for (int i = 0; i < 16; i++) begin
            read_idx(4'(i), d);
            n_checks++; if (d !== 128'h0) begin n_fail++; $display("FAIL clear_zero idx=%0d: got %h want 0", i, d); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clear_done idx=%0d: got %b want 0", i, done); end
        end
        #1;
        n_checks++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL clear_idle_ready: got %b want 1", key_ready); end
    endtask

    // rst at step 9, then a fresh C.3 expansion completes in 13 cycles.
    task automatic test_rst_mid();
        logic [127:0] d;
        int cycles;
        rk_rd_idx = 4'd0;
        start_key(C3_KEY);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL rst_kv: got %b want 0", keys_valid); end
        n_checks++; if (rk_avail !== 4'd0) begin n_fail++; $display("FAIL rst_avail: got %0d want 0", rk_avail); end
        n_checks++; if (rk_rd_data !== 128'h0) begin n_fail++; $display("FAIL rst_rd: got %h want 0", rk_rd_data); end
        start_key(C3_KEY);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++; if (cycles !== 13) begin n_fail++; $display("FAIL rst_relatency: got %0d want 13", cycles); end
        n_checks++; if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL rst_rekv: got %b want 1", keys_valid); end
        read_idx(4'd14, d);
        n_checks++; if (d !== C3_RK14) begin n_fail++; $display("FAIL rst_rk14: got %h want %h", d, C3_RK14); end
        read_idx(4'd5, d);
        n_checks++; if (d !== C3_RK5) begin n_fail++; $display("FAIL rst_rk5: got %h want %h", d, C3_RK5); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_c3_expand();
        test_rekey_a3();
        test_clear_mid();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
